// File: rtl/hs_fifo_if.sv
// rtl/hs_fifo_if.sv - req/ack token channel; master sources tokens, slave sinks them
interface hs_fifo_if #(
    parameter int data_width = 32
) ();
    logic                  req;
    logic                  ack;
    logic [data_width-1:0] data;

    modport master (input req, output ack, output data);
    modport slave  (output req, input ack, input data);
endinterface

// File: rtl/hs_fifo.sv
// rtl/hs_fifo.sv - elastic req/ack token buffer with occupancy and sticky protocol-error flag
module hs_fifo #(
    parameter int                    data_width    = 32,
    parameter int                    depth         = 4,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    hs_fifo_if.slave               up,
    hs_fifo_if.master              dn,
    output logic [$clog2(depth):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   err
);
    localparam int            aw      = $clog2(depth);
    localparam logic [aw:0]   depth_c = (aw + 1)'(depth);

    typedef enum logic {S_IDLE, S_WAIT} up_state_t;

    up_state_t             state, state_next;
    logic [aw-1:0]         wr_ptr, rd_ptr;
    logic [data_width-1:0] mem [depth];
    logic                  wr_en, rd_en, proto_err;

    assign full  = (count == depth_c);
    assign empty = (count == '0);

    // An ack while no request is outstanding is dropped and flagged.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        proto_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (up.ack)
                    proto_err = 1'b1;
                else if (count < depth_c)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (up.ack) begin
                    wr_en      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign up.req = (state == S_WAIT);

    // Blocking on our own ack spaces downstream acknowledges two cycles apart.
    assign rd_en = dn.req && !dn.ack && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dn.ack  <= 1'b0;
            dn.data <= initial_value;
            err     <= 1'b0;
        end else begin
            state  <= state_next;
            dn.ack <= rd_en;
            if (proto_err)
                err <= 1'b1;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                dn.data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= up.data;
    end
endmodule

// File: tb/tb_hs_fifo.sv
// tb/tb_hs_fifo.sv - randomized/directed bench for hs_fifo against a queue-based token model
module tb_hs_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] count;
    logic       full, empty, err;

    hs_fifo_if #(.data_width(DW)) up_if ();
    hs_fifo_if #(.data_width(DW)) dn_if ();

    hs_fifo #(.data_width(DW), .depth(DEPTH), .initial_value('0)) dut (
        .clk   (clk),
        .rst   (rst_n),
        .up    (up_if),
        .dn    (dn_if),
        .count (count),
        .full  (full),
        .empty (empty),
        .err   (err)
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] q[$];
    logic        m_req, m_ack_r, m_err;
    logic [31:0] m_dout;
    logic        prod_en, req_r_drv, inject;
    logic [31:0] tok;
    int          writes, got;
    logic        dead_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        q.delete();
        m_req   = 1'b0;
        m_ack_r = 1'b0;
        m_err   = 1'b0;
        m_dout  = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_l"}, up_if.req, 0);
        chk({tag, "_ack_r"}, dn_if.ack, 0);
        chk({tag, "_dout"},  dn_if.data, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"},  full, 0);
        chk({tag, "_err"},   err, 0);
    endtask

    // One clock cycle: drive at the falling edge, predict, check at the next falling edge.
    task automatic tick();
        int  sz;
        logic wr, rd, ev;
        up_if.ack  = 1'b0;
        up_if.data = $urandom;
        if (inject) begin
            up_if.ack  = 1'b1;
            up_if.data = 32'hDEAD;
        end else if (prod_en && up_if.req) begin
            up_if.ack  = 1'b1;
            up_if.data = tok;
            tok++;
        end
        dn_if.req = req_r_drv;
        sz = q.size();
        wr = up_if.ack && m_req;
        ev = up_if.ack && !m_req;
        rd = req_r_drv && !m_ack_r && (sz > 0);
        if (rd) begin
            m_dout = q.pop_front();
            got++;
        end
        if (wr) begin
            q.push_back(up_if.data);
            writes++;
        end
        if (ev) m_err = 1'b1;
        m_req   = m_req ? !up_if.ack : (!up_if.ack && sz < DEPTH);
        m_ack_r = rd;
        @(posedge clk);
        @(negedge clk);
        up_if.ack = 1'b0;
        if (dn_if.ack && dn_if.data == 32'hDEAD) dead_seen = 1'b1;
        chk("req_l", up_if.req, m_req);
        chk("ack_r", dn_if.ack, m_ack_r);
        chk("dout",  dn_if.data, m_dout);
        chk("count", count, 32'(q.size()));
        chk("full",  full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("err",   err, m_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        up_if.ack  = 1'b0;
        up_if.data = '0;
        dn_if.req  = 1'b1;
        prod_en    = 1'b0;
        req_r_drv  = 1'b1;
        inject     = 1'b0;
        tok        = 0;
        writes     = 0;
        got        = 0;
        dead_seen  = 1'b0;
        m_reset();

        // Reset held three cycles with req_r high; first req_l on the first edge after release.
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        chk("first_req", up_if.req, 1);

        // Ordering: 0..99 with the consumer always requesting.
        tok = 0; got = 0; prod_en = 1'b1; req_r_drv = 1'b1;
        for (int i = 0; i < 1000 && got < 100; i++) tick();
        chk("order_got", got, 100);
        chk("order_err", err, 0);

        // Fill to full, hold, inject a protocol error, then pulse one read.
        do_reset();
        tok = 10; writes = 0; prod_en = 1'b1; req_r_drv = 1'b0;
        for (int i = 0; i < 50 && writes < 4; i++) tick();
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        repeat (20) tick();
        chk("full_hold_req", up_if.req, 0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("perr_err", err, 1);
        chk("perr_count", count, 4);
        req_r_drv = 1'b1;
        tick();
        chk("pulse_ack", dn_if.ack, 1);
        chk("pulse_dout", dn_if.data, 10);
        chk("pulse_count", count, 3);
        req_r_drv = 1'b0;
        tick();
        chk("rearm_req", up_if.req, 1);
        prod_en = 1'b0; req_r_drv = 1'b1;
        for (int i = 0; i < 100 && q.size() > 0; i++) tick();
        chk("perr_drained", count, 0);
        chk("perr_sticky", err, 1);
        chk("dead_never", dead_seen, 0);

        // Wrap-around: 10 bursts of 3 writes then a full drain.
        do_reset();
        tok = 100; got = 0;
        for (int b = 0; b < 10; b++) begin
            writes = 0; prod_en = 1'b1; req_r_drv = 1'b0;
            for (int i = 0; i < 60 && writes < 3; i++) tick();
            prod_en = 1'b0; req_r_drv = 1'b1;
            for (int i = 0; i < 60 && q.size() > 0; i++) tick();
        end
        chk("wrap_got", got, 30);
        chk("wrap_last", dn_if.data, 129);

        // Simultaneous write and read at count 2.
        tok = 200; writes = 0; prod_en = 1'b1; req_r_drv = 1'b0;
        for (int i = 0; i < 50 && writes < 2; i++) tick();
        prod_en = 1'b0;
        for (int i = 0; i < 5 && !up_if.req; i++) tick();
        chk("sim_pre_count", count, 2);
        chk("sim_pre_req", up_if.req, 1);
        prod_en = 1'b1; req_r_drv = 1'b1;
        tick();
        chk("sim_count", count, 2);
        chk("sim_dout", dn_if.data, 200);
        prod_en = 1'b0;
        for (int i = 0; i < 50 && q.size() > 0; i++) tick();
        tick();
        chk("sim_last", dn_if.data, 202);

        // Asynchronous reset mid-cycle during traffic.
        prod_en = 1'b1; req_r_drv = 1'b1; tok = $urandom_range(1000, 2000);
        repeat (15) tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_async_req", up_if.req, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
